rns_fir_filter: RTL and testbench

- 4-tap FIR filter. Integer samples are converted to a residue number system (RNS) on entry. Filtering runs as four independent modular channels, and the result is converted back to an integer by CRT.
- Moduli are 233, 239, 241, 251. Dynamic range M = 3,368,562,317, which fits in 32 bits.
- Sits between the integer sample source and downstream integer consumers. It demonstrates carry-free RNS arithmetic in the datapath.

---
 rtl/rns_pkg.sv | 70 +++++++
 rtl/rns_channel_fir.sv | 50 +++++
 rtl/rns_fir_filter.sv | 65 ++++++
 tb/tb_rns_fir_filter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rns_pkg.sv
// RNS constants, residue vector type and conversion helpers.
// Moduli 233/239/241/251; CRT weights are derived at elaboration.
package rns_pkg;

  localparam int unsigned M0 = 233;
  localparam int unsigned M1 = 239;
  localparam int unsigned M2 = 241;
  localparam int unsigned M3 = 251;

  localparam logic [63:0] M =
    64'(M0) * 64'(M1) * 64'(M2) * 64'(M3);

  localparam logic [63:0] MHAT0 = M / 64'(M0);
  localparam logic [63:0] MHAT1 = M / 64'(M1);
  localparam logic [63:0] MHAT2 = M / 64'(M2);
  localparam logic [63:0] MHAT3 = M / 64'(M3);

  function automatic logic [63:0] inv_mod(
    input logic [63:0] a,
    input logic [63:0] m
  );
    logic [63:0] res;
    res = '0;
    for (int k = 1; k < 256; k++)
      if (64'(k) < m && ((a % m) * 64'(k)) % m == 64'd1)
        res = 64'(k);
    return res;
  endfunction

  localparam logic [63:0] INV0 = inv_mod(MHAT0, 64'(M0));
  localparam logic [63:0] INV1 = inv_mod(MHAT1, 64'(M1));
  localparam logic [63:0] INV2 = inv_mod(MHAT2, 64'(M2));
  localparam logic [63:0] INV3 = inv_mod(MHAT3, 64'(M3));

  // Pre-reduced CRT weights keep each product under 2^40.
  localparam logic [63:0] CRT0 = (MHAT0 * INV0) % M;
  localparam logic [63:0] CRT1 = (MHAT1 * INV1) % M;
  localparam logic [63:0] CRT2 = (MHAT2 * INV2) % M;
  localparam logic [63:0] CRT3 = (MHAT3 * INV3) % M;

  typedef struct packed {
    logic [7:0] r3;
    logic [7:0] r2;
    logic [7:0] r1;
    logic [7:0] r0;
  } rns_vec_t;

  function automatic rns_vec_t int_to_rns(
    input logic [63:0] v
  );
    rns_vec_t r;
    r.r0 = 8'(v % 64'(M0));
    r.r1 = 8'(v % 64'(M1));
    r.r2 = 8'(v % 64'(M2));
    r.r3 = 8'(v % 64'(M3));
    return r;
  endfunction

  function automatic logic [31:0] rns_to_int(
    input rns_vec_t r
  );
    logic [63:0] acc;
    acc = 64'(r.r0) * CRT0
        + 64'(r.r1) * CRT1
        + 64'(r.r2) * CRT2
        + 64'(r.r3) * CRT3;
    return 32'(acc % M);
  endfunction

endpackage

// File: rtl/rns_channel_fir.sv
// One residue channel: 4-tap delay line, modular MAC, output reg.
// Ports: clk, reset (sync, active-low), r residue in, s residue out.
module rns_channel_fir #(
  parameter int unsigned MOD = 233,
  parameter int unsigned H0  = 1,
  parameter int unsigned H1  = 2,
  parameter int unsigned H2  = 3,
  parameter int unsigned H3  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] r,
  output logic [7:0] s
);

  localparam logic [7:0] C0 = 8'(H0 % MOD);
  localparam logic [7:0] C1 = 8'(H1 % MOD);
  localparam logic [7:0] C2 = 8'(H2 % MOD);
  localparam logic [7:0] C3 = 8'(H3 % MOD);

  logic [7:0]  tap0, tap1, tap2, tap3;
  logic [17:0] acc;
  logic [7:0]  mac;

  // Four 8x8 products sum below 2^18.
  always_comb begin
    acc = 18'(C0) * 18'(tap0)
        + 18'(C1) * 18'(tap1)
        + 18'(C2) * 18'(tap2)
        + 18'(C3) * 18'(tap3);
    mac = 8'(acc % 18'(MOD));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tap0 <= '0;
      tap1 <= '0;
      tap2 <= '0;
      tap3 <= '0;
      s    <= '0;
    end else begin
      tap0 <= r;
      tap1 <= tap0;
      tap2 <= tap1;
      tap3 <= tap2;
      s    <= mac;
    end
  end

endmodule

// File: rtl/rns_fir_filter.sv
// 4-tap FIR in residue arithmetic with CRT back-conversion.
// Ports: clk, reset (sync, active-low), x in, y out, y_rns out.
// Macro RNS_SIGNED_OUT_EN: signed input and symmetric output.
module rns_fir_filter
  import rns_pkg::*;
#(
  parameter int unsigned H0 = 1,
  parameter int unsigned H1 = 2,
  parameter int unsigned H2 = 3,
  parameter int unsigned H3 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] x,
  output logic [31:0] y,
  output logic [31:0] y_rns
);

  localparam int unsigned MODS [4] = '{M0, M1, M2, M3};

  logic [63:0]      x_ext;
  rns_vec_t         x_rns;
  rns_vec_t         s_rns;
  logic [3:0][7:0]  x_ch;
  logic [3:0][7:0]  s_ch;
  logic [31:0]      r_int;

`ifdef RNS_SIGNED_OUT_EN
  // Negative x becomes M + x; the 64-bit add wraps to M - |x|.
  assign x_ext = x[31] ? M + {32'hFFFF_FFFF, x}
                       : {32'd0, x};
`else
  assign x_ext = {32'd0, x};
`endif

  assign x_rns = int_to_rns(x_ext);
  assign x_ch  = x_rns;

  for (genvar i = 0; i < 4; i++) begin : g_ch
    rns_channel_fir #(
      .MOD (MODS[i]),
      .H0  (H0),
      .H1  (H1),
      .H2  (H2),
      .H3  (H3)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .r     (x_ch[i]),
      .s     (s_ch[i])
    );
  end

  assign s_rns = s_ch;
  assign y_rns = s_rns;
  assign r_int = rns_to_int(s_rns);

`ifdef RNS_SIGNED_OUT_EN
  localparam logic [31:0] HALF = 32'((M - 64'd1) / 64'd2);
  assign y = (r_int > HALF) ? r_int - 32'(M) : r_int;
`else
  assign y = r_int;
`endif

endmodule

// File: tb/tb_rns_fir_filter.sv
// Scoreboard bench for rns_fir_filter.
// Integer-domain model; expected results queued per input sample.
module tb_rns_fir_filter;

  localparam logic [63:0] MM = 64'd3368562317;

  logic        clk;
  logic        reset;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] y_rns;

  int n_chk;
  int n_fail;

  logic [63:0] hist [4];
  logic [63:0] sb [$];

  rns_fir_filter dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y),
    .y_rns (y_rns)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] eff_x(input logic [31:0] v);
`ifdef RNS_SIGNED_OUT_EN
    if (v[31])
      return MM - (64'h1_0000_0000 - {32'd0, v});
`endif
    return {32'd0, v} % MM;
  endfunction

  function automatic logic [31:0] exp_y(input logic [63:0] r);
`ifdef RNS_SIGNED_OUT_EN
    if (r > (MM - 64'd1) / 64'd2)
      return 32'(r - MM);
`endif
    return 32'(r);
  endfunction

  function automatic logic [31:0] exp_rns(input logic [63:0] r);
    logic [7:0] a, b, c, d;
    a = 8'(r % 64'd233);
    b = 8'(r % 64'd239);
    c = 8'(r % 64'd241);
    d = 8'(r % 64'd251);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] filt();
    return (64'd1 * hist[0] + 64'd2 * hist[1]
          + 64'd3 * hist[2] + 64'd4 * hist[3]) % MM;
  endfunction

  // One clock: drive x/reset, then score the output after the edge.
  task automatic step(input logic [31:0] xv, input logic rv);
    logic [63:0] r_now;
    @(negedge clk);
    x     = xv;
    reset = rv;
    @(posedge clk);
    #1;
    r_now = 64'd0;
    if (!rv) begin
      sb.delete();
      for (int i = 0; i < 4; i++) hist[i] = 64'd0;
      sb.push_back(64'd0);
    end else begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_empty got=0 exp=1");
      end else begin
        r_now = sb.pop_front();
      end
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = eff_x(xv);
      sb.push_back(filt());
    end
    check("y", {32'd0, y}, {32'd0, exp_y(r_now)});
    check("y_rns", {32'd0, y_rns}, {32'd0, exp_rns(r_now)});
  endtask

  initial begin
    logic [31:0] ramp [10];
    ramp = '{0, 1, 4, 10, 20, 30, 40, 50, 60, 70};
    clk    = 1'b0;
    reset  = 1'b0;
    x      = 32'd0;
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 4; i++) hist[i] = 64'd0;

    step(32'd123, 1'b0);
    step(32'd123, 1'b0);
    check("rst_y", {32'd0, y}, 64'd0);
    check("rst_rns", {32'd0, y_rns}, 64'd0);
    for (int i = 0; i < 3; i++) step(32'd0, 1'b1);
    check("idle_y", {32'd0, y}, 64'd0);

    for (int k = 0; k <= 10; k++) begin
      step(k < 10 ? 32'(k) : 32'd0, 1'b1);
      if (k >= 1)
        check("ramp", {32'd0, y}, {32'd0, ramp[k-1]});
    end
    for (int i = 0; i < 4; i++) step(32'd0, 1'b1);

    step(32'd1, 1'b1);
    step(32'd0, 1'b1);
    check("imp_y", {32'd0, y}, 64'd1);
    check("imp_rns", {32'd0, y_rns}, 64'h0101_0101);
    for (int i = 0; i < 5; i++) step(32'd0, 1'b1);

    step(32'(MM - 64'd1), 1'b1);
    for (int i = 0; i < 5; i++) step(32'd0, 1'b1);

    step(32'hFFFF_FFFF, 1'b1);
    for (int i = 0; i < 5; i++) step(32'd0, 1'b1);

    for (int k = 0; k < 5; k++) step(32'(k), 1'b1);
    step(32'd99, 1'b0);
    check("mid_rst", {32'd0, y}, 64'd0);
    step(32'd5, 1'b1);
    step(32'd6, 1'b1);
    check("restart0", {32'd0, y}, 64'd5);
    step(32'd0, 1'b1);
    check("restart1", {32'd0, y}, 64'd16);
    for (int i = 0; i < 4; i++) step(32'd0, 1'b1);

    for (int i = 0; i < 40; i++)
      step($urandom_range(32'd1684281158, 0), 1'b1);
    for (int i = 0; i < 5; i++) step(32'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
